ita_step_sequencer: RTL and testbench
=====================================

Name: ita_step_sequencer

Overview:
Parametrised step/tile sequencer for the ITA accelerator. It walks the step_e sequence required by the configured layer (Attention, SingleAttention, Feedforward, Linear) across H heads. For each step it emits one tile command per (outer, middle, inner) tile index via a valid/ready handshake. It sits between the ctrl_t register interface and the datapath controller, and replaces fixed single-head, single-tile sequencing.

Parameters:
H, 1, maximum number of heads supported.
TileWidth, 16, width of each tile count and tile index.
HeadWidth, idx_width(H), width of the head index.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  start pulse; sampled only in IDLE
abort_i  input  1  synchronous abort; return to IDLE
layer_i  input  2  layer_e
n_heads_i  input  HeadWidth+1  heads to run, valid range 1..H
tile_s_i/tile_e_i/tile_p_i/tile_f_i  input  TileWidth each  tile counts per dimension
valid_o  output  1  tile command valid
ready_i  input  1  datapath accepts command
step_o  output  4  step_e of current command
head_o  output  HeadWidth  current head
tile_a_o/tile_b_o/tile_k_o  output  TileWidth each  outer/middle/inner (accumulation) indices
last_k_o  output  1  tile_k_o is the final accumulation tile
busy_o  output  1  not IDLE
done_o  output  1  one-cycle pulse at completion
error_o  output  1  one-cycle pulse on rejected config

Behaviour:
- Interface fixed: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: every output is 0 and step_o=Idle. The FSM goes to IDLE and all counters clear. Reset mid-run discards the run with no done_o.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 with a valid config: register the config, load the first step and zero all indices, go to RUN. valid_o=1 from the next cycle (latency 1).
  - start_i=1 with an invalid config: error_o pulses the next cycle and the FSM stays in IDLE. Invalid means any tile count used by the layer is 0, or (for attention layers) n_heads_i is 0 or greater than H.
  - Config inputs are ignored outside IDLE; start_i outside IDLE is ignored.
- Step order:
  - Attention: per head, Q,K,V,QK,AV,OW.
  - SingleAttention: per head, Q,K,V,QK,AV.
  - Feedforward: F1,F2, head_o=0.
  - Linear: MatMul, head_o=0.
- Tile loop bounds (a × b × k):
  - Q/K/V: s × p × e.
  - QK: s × s × p.
  - AV: s × p × s.
  - OW: s × e × p.
  - F1: s × f × e.
  - F2: s × e × f.
  - MatMul: s × f × e.
- Handshake:
  - The command advances only on valid_o&&ready_i.
  - Outputs are held stable while valid_o=1 and ready_i=0.
  - valid_o stays high continuously through RUN, so back-to-back commands run at one per cycle.
- Advance order on each handshake:
  - k increments; on k wrap (k==bound-1), b increments; on b wrap, a increments.
  - On a wrap, go to the next step; on last-step wrap, go to the next head; on last-head wrap, go to DONE.
  - last_k_o = (k==k_bound-1).
- DONE: valid_o=0, done_o=1 for one cycle, then IDLE. busy_o=1 in RUN and DONE.
- abort_i: takes priority over the handshake in the same cycle. The FSM goes to IDLE the next cycle with valid_o=0 and no done_o. abort_i in IDLE has no effect.
- Bound of 1: the index stays 0 and wraps on every handshake.
- Bounds are compared as full TileWidth unsigned values with no overflow; a count of 2^TileWidth−1 is legal.

Decomposition:
- ita_package additions:
  - tile_idx_t (TileWidth).
  - seq_state_e {SeqIdle, SeqRun, SeqDone}.
  - Function first_step(layer_e) and function next_step(layer_e, step_e), returning step_e; Idle means the sequence ended.
- Sub-module ita_tile_counter: three nested wrap counters with per-level bounds, inputs en_i/clear_i/bounds, outputs indices and wrap_o. It is instantiated once and reloaded with new bounds on each step change.

Test Plan:
- Attention, H=1, n_heads=1, s=2,e=1,p=1, ready_i=1 -> 16 commands: Q2,K2,V2,QK4,AV4,OW2. QK indices (a,b) run 00,01,10,11. done_o pulses the cycle after the last handshake. Reset check: all outputs 0.
- Feedforward s=1,e=2,f=3 -> F1 gives 6 commands and last_k_o on every 2nd command; F2 gives 6 commands and last_k_o on every 3rd; head_o=0 throughout.
- H=4, SingleAttention, n_heads=3, all tiles=1 -> 15 commands, head_o 0,0,0,0,0,1,…,2, no OW step. Repeat with n_heads=5 or tile_p=0 -> error_o pulse, busy_o stays 0.
- Linear s=1,f=1,e=3 with random ready_i stalls -> outputs stable during stalls; exactly 3 MatMul commands with k=0,1,2.
- Abort on the same cycle as a handshake mid-QK -> valid_o=0 the next cycle, no done_o; a fresh start then begins again at Q with zero indices.
- start_i while busy plus rst_i mid-run -> the start is ignored; the reset clears the FSM to IDLE with all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ita_step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : ita_step_sequencer_pkg
// Brief   : Shared types and step-ordering helpers for the ITA step sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package ita_step_sequencer_pkg;

    localparam int c_TILE_WIDTH = 16;

    typedef logic [c_TILE_WIDTH-1:0] tile_idx_t;

    typedef enum logic [1:0] {
        Attention       = 2'd0,
        Feedforward     = 2'd1,
        Linear          = 2'd2,
        SingleAttention = 2'd3
    } layer_e;

    typedef enum logic [3:0] {
        Idle   = 4'd0,
        Q      = 4'd1,
        K      = 4'd2,
        V      = 4'd3,
        QK     = 4'd4,
        AV     = 4'd5,
        OW     = 4'd6,
        F1     = 4'd7,
        F2     = 4'd8,
        MatMul = 4'd9
    } step_e;

    typedef enum logic [1:0] {
        SeqIdle = 2'd0,
        SeqRun  = 2'd1,
        SeqDone = 2'd2
    } seq_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_attention(input layer_e layer);
        return (layer == Attention) || (layer == SingleAttention);
    endfunction

    function automatic step_e first_step(input layer_e layer);
        case (layer)
            Attention, SingleAttention: return Q;
            Feedforward:                return F1;
            Linear:                     return MatMul;
            default:                    return Idle;
        endcase
    endfunction

    // Idle as a return value marks the end of the per-head sequence.
    function automatic step_e next_step(input layer_e layer, input step_e step);
        case (step)
            Q:       return K;
            K:       return V;
            V:       return QK;
            QK:      return AV;
            AV:      return (layer == Attention) ? OW : Idle;
            F1:      return F2;
            default: return Idle;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ita_tile_counter.sv
`default_nettype none
// ============================================================================
// Module : ita_tile_counter
// Brief  : Three nested wrap counters (a outer, b middle, k inner).
// Rev    : 1.0  initial release
// ============================================================================
module ita_tile_counter #(
    parameter int TileWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [TileWidth-1:0] bound_a_i,
    input  logic [TileWidth-1:0] bound_b_i,
    input  logic [TileWidth-1:0] bound_k_i,
    output logic [TileWidth-1:0] idx_a_o,
    output logic [TileWidth-1:0] idx_b_o,
    output logic [TileWidth-1:0] idx_k_o,
    output logic                 last_k_o,
    output logic                 wrap_o
);

    localparam logic [TileWidth-1:0] c_ONE = TileWidth'(1);

    logic [TileWidth-1:0] r_a;
    logic [TileWidth-1:0] r_b;
    logic [TileWidth-1:0] r_k;
    logic                 w_last_a;
    logic                 w_last_b;
    logic                 w_last_k;

    // Bounds are never zero while counting, so bound-1 cannot underflow.
    assign w_last_a = (r_a == (bound_a_i - c_ONE));
    assign w_last_b = (r_b == (bound_b_i - c_ONE));
    assign w_last_k = (r_k == (bound_k_i - c_ONE));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_a <= '0;
            r_b <= '0;
            r_k <= '0;
        end else if (en_i) begin
            if (w_last_k) begin
                r_k <= '0;
                if (w_last_b) begin
                    r_b <= '0;
                    r_a <= w_last_a ? '0 : (r_a + c_ONE);
                end else begin
                    r_b <= r_b + c_ONE;
                end
            end else begin
                r_k <= r_k + c_ONE;
            end
        end
    end

    assign idx_a_o  = r_a;
    assign idx_b_o  = r_b;
    assign idx_k_o  = r_k;
    assign last_k_o = w_last_k;
    assign wrap_o   = en_i && w_last_a && w_last_b && w_last_k;

endmodule
`default_nettype wire

// File: rtl/ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ita_step_sequencer
// Brief  : Walks the layer step sequence over heads, issuing one tile command
//          per (a, b, k) index through a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module ita_step_sequencer
    import ita_step_sequencer_pkg::*;
#(
    parameter int H         = 1,
    parameter int TileWidth = 16,
    parameter int HeadWidth = idx_width(H)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [1:0]           layer_i,
    input  logic [HeadWidth:0]   n_heads_i,
    input  logic [TileWidth-1:0] tile_s_i,
    input  logic [TileWidth-1:0] tile_e_i,
    input  logic [TileWidth-1:0] tile_p_i,
    input  logic [TileWidth-1:0] tile_f_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [3:0]           step_o,
    output logic [HeadWidth-1:0] head_o,
    output logic [TileWidth-1:0] tile_a_o,
    output logic [TileWidth-1:0] tile_b_o,
    output logic [TileWidth-1:0] tile_k_o,
    output logic                 last_k_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam logic [HeadWidth:0]   c_H_MAX     = (HeadWidth+1)'(H);
    localparam logic [HeadWidth:0]   c_NHEAD_ONE = (HeadWidth+1)'(1);
    localparam logic [HeadWidth-1:0] c_HEAD_ONE  = HeadWidth'(1);

    seq_state_e           r_state;
    layer_e               r_layer;
    step_e                r_step;
    logic [HeadWidth-1:0] r_head;
    logic [HeadWidth:0]   r_n_heads;
    logic [TileWidth-1:0] r_tile_s;
    logic [TileWidth-1:0] r_tile_e;
    logic [TileWidth-1:0] r_tile_p;
    logic [TileWidth-1:0] r_tile_f;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_error;

    layer_e               w_layer_in;
    logic                 w_cfg_ok;
    logic                 w_load;
    logic                 w_fire;
    logic                 w_abort;
    logic                 w_wrap;
    logic                 w_last_k;
    logic                 w_last_head;
    step_e                w_next;
    logic [TileWidth-1:0] w_bound_a;
    logic [TileWidth-1:0] w_bound_b;
    logic [TileWidth-1:0] w_bound_k;

    assign w_layer_in = layer_e'(layer_i);

    // Only tile counts the layer actually consumes are checked for zero.
    always_comb begin
        w_cfg_ok = (tile_s_i != '0) && (tile_e_i != '0);
        if (is_attention(w_layer_in)) begin
            w_cfg_ok = w_cfg_ok && (tile_p_i != '0) &&
                       (n_heads_i != '0) && (n_heads_i <= c_H_MAX);
        end else begin
            w_cfg_ok = w_cfg_ok && (tile_f_i != '0);
        end
    end

    assign w_load      = (r_state == SeqIdle) && start_i && w_cfg_ok;
    assign w_abort     = (r_state == SeqRun) && abort_i;
    assign w_fire      = (r_state == SeqRun) && r_valid && ready_i && !abort_i;
    assign w_next      = next_step(r_layer, r_step);
    assign w_last_head = ({1'b0, r_head} == (r_n_heads - c_NHEAD_ONE));

    always_comb begin
        w_bound_a = r_tile_s;
        w_bound_b = '0;
        w_bound_k = '0;
        case (r_step)
            Q, K, V:    begin w_bound_b = r_tile_p; w_bound_k = r_tile_e; end
            QK:         begin w_bound_b = r_tile_s; w_bound_k = r_tile_p; end
            AV:         begin w_bound_b = r_tile_p; w_bound_k = r_tile_s; end
            OW:         begin w_bound_b = r_tile_e; w_bound_k = r_tile_p; end
            F1, MatMul: begin w_bound_b = r_tile_f; w_bound_k = r_tile_e; end
            F2:         begin w_bound_b = r_tile_e; w_bound_k = r_tile_f; end
            default:    begin w_bound_a = '0; end
        endcase
    end

    ita_tile_counter #(
        .TileWidth (TileWidth)
    ) u_tile_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_load || w_abort),
        .en_i      (w_fire),
        .bound_a_i (w_bound_a),
        .bound_b_i (w_bound_b),
        .bound_k_i (w_bound_k),
        .idx_a_o   (tile_a_o),
        .idx_b_o   (tile_b_o),
        .idx_k_o   (tile_k_o),
        .last_k_o  (w_last_k),
        .wrap_o    (w_wrap)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= SeqIdle;
            r_layer   <= Attention;
            r_step    <= Idle;
            r_head    <= '0;
            r_n_heads <= '0;
            r_tile_s  <= '0;
            r_tile_e  <= '0;
            r_tile_p  <= '0;
            r_tile_f  <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                SeqIdle: begin
                    if (w_load) begin
                        r_layer   <= w_layer_in;
                        r_n_heads <= n_heads_i;
                        r_tile_s  <= tile_s_i;
                        r_tile_e  <= tile_e_i;
                        r_tile_p  <= tile_p_i;
                        r_tile_f  <= tile_f_i;
                        r_step    <= first_step(w_layer_in);
                        r_head    <= '0;
                        r_valid   <= 1'b1;
                        r_state   <= SeqRun;
                    end else if (start_i) begin
                        r_error <= 1'b1;
                    end
                end
                SeqRun: begin
                    if (w_abort) begin
                        r_state <= SeqIdle;
                        r_valid <= 1'b0;
                        r_step  <= Idle;
                        r_head  <= '0;
                    end else if (w_fire && w_wrap) begin
                        if (w_next != Idle) begin
                            r_step <= w_next;
                        end else if (is_attention(r_layer) && !w_last_head) begin
                            r_head <= r_head + c_HEAD_ONE;
                            r_step <= first_step(r_layer);
                        end else begin
                            r_state <= SeqDone;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_step  <= Idle;
                            r_head  <= '0;
                        end
                    end
                end
                SeqDone: begin
                    r_state <= SeqIdle;
                end
                default: begin
                    r_state <= SeqIdle;
                end
            endcase
        end
    end

    // last_k is qualified by valid so it reads 0 whenever no command is presented.
    assign valid_o  = r_valid;
    assign step_o   = r_step;
    assign head_o   = r_head;
    assign last_k_o = r_valid && w_last_k;
    assign busy_o   = (r_state != SeqIdle);
    assign done_o   = r_done;
    assign error_o  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ita_step_sequencer
// Brief  : Table-driven check of ita_step_sequencer plus corner-case sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ita_step_sequencer;
    import ita_step_sequencer_pkg::*;

    localparam int c_H  = 4;
    localparam int c_TW = 16;
    localparam int c_HW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [1:0]      layer;
    logic [c_HW:0]   n_heads;
    logic [c_TW-1:0] tile_s, tile_e, tile_p, tile_f;
    logic            valid;
    logic            ready;
    logic [3:0]      step;
    logic [c_HW-1:0] head;
    logic [c_TW-1:0] tile_a, tile_b, tile_k;
    logic            last_k, busy, done, error;

    ita_step_sequencer #(
        .H         (c_H),
        .TileWidth (c_TW),
        .HeadWidth (c_HW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .abort_i   (abort),
        .layer_i   (layer),
        .n_heads_i (n_heads),
        .tile_s_i  (tile_s),
        .tile_e_i  (tile_e),
        .tile_p_i  (tile_p),
        .tile_f_i  (tile_f),
        .valid_o   (valid),
        .ready_i   (ready),
        .step_o    (step),
        .head_o    (head),
        .tile_a_o  (tile_a),
        .tile_b_o  (tile_b),
        .tile_k_o  (tile_k),
        .last_k_o  (last_k),
        .busy_o    (busy),
        .done_o    (done),
        .error_o   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      stp;
        logic [c_HW-1:0] hd;
        logic [15:0]     a, b, k;
        logic            lk;
    } cmd_t;

    typedef struct {
        layer_e ly;
        int     nh;
        int     s, e, p, f;
        int     n_cmds;
        bit     err;
        bit     stall;
    } vec_t;

    cmd_t exp_q[$];
    vec_t tbl[11];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bounds_for(input step_e st, input int s, input int e, input int p,
                              input int f, output int ba, output int bb, output int bk);
        ba = s;
        case (st)
            QK:         begin bb = s; bk = p; end
            AV:         begin bb = p; bk = s; end
            OW:         begin bb = e; bk = p; end
            F1, MatMul: begin bb = f; bk = e; end
            F2:         begin bb = e; bk = f; end
            default:    begin bb = p; bk = e; end
        endcase
    endtask

    task automatic build(input vec_t v);
        step_e seq[$];
        int    nhd;
        int    ba, bb, bk;
        cmd_t  c;
        exp_q.delete();
        case (v.ly)
            Attention:       seq = '{Q, K, V, QK, AV, OW};
            SingleAttention: seq = '{Q, K, V, QK, AV};
            Feedforward:     seq = '{F1, F2};
            default:         seq = '{MatMul};
        endcase
        nhd = (v.ly == Attention || v.ly == SingleAttention) ? v.nh : 1;
        for (int h = 0; h < nhd; h++) begin
            foreach (seq[i]) begin
                bounds_for(seq[i], v.s, v.e, v.p, v.f, ba, bb, bk);
                for (int ia = 0; ia < ba; ia++)
                    for (int ib = 0; ib < bb; ib++)
                        for (int ik = 0; ik < bk; ik++) begin
                            c.stp = seq[i];
                            c.hd  = h[c_HW-1:0];
                            c.a   = ia[15:0];
                            c.b   = ib[15:0];
                            c.k   = ik[15:0];
                            c.lk  = (ik == bk - 1);
                            exp_q.push_back(c);
                        end
            end
        end
    endtask

    task automatic check_cmd(input cmd_t c, input int idx);
        string t;
        t = $sformatf("cmd%0d", idx);
        chk({t, " step"},   step,   c.stp);
        chk({t, " head"},   head,   c.hd);
        chk({t, " a"},      tile_a, c.a);
        chk({t, " b"},      tile_b, c.b);
        chk({t, " k"},      tile_k, c.k);
        chk({t, " last_k"}, last_k, c.lk);
    endtask

    task automatic start_cfg(input layer_e ly, input int nh, input int s, input int e,
                             input int p, input int f);
        layer   = ly;
        n_heads = nh[c_HW:0];
        tile_s  = s[15:0];
        tile_e  = e[15:0];
        tile_p  = p[15:0];
        tile_f  = f[15:0];
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int n;
        int cyc;
        bit hs;
        build(v);
        ready = 1'b0;
        start_cfg(v.ly, v.nh, v.s, v.e, v.p, v.f);
        if (v.err) begin
            chk($sformatf("v%0d error_pulse", vi), error, 1);
            chk($sformatf("v%0d err_busy", vi), busy, 0);
            chk($sformatf("v%0d err_valid", vi), valid, 0);
            tick();
            chk($sformatf("v%0d error_clear", vi), error, 0);
            chk($sformatf("v%0d err_busy2", vi), busy, 0);
            return;
        end
        chk($sformatf("v%0d no_error", vi), error, 0);
        chk($sformatf("v%0d busy", vi), busy, 1);
        n = 0;
        cyc = 0;
        while (n < v.n_cmds && cyc < 4 * v.n_cmds + 20) begin
            if (valid) check_cmd(exp_q[n], n);
            else chk($sformatf("v%0d valid_run", vi), valid, 1);
            ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = valid && ready;
            tick();
            cyc++;
            if (hs) n++;
        end
        ready = 1'b0;
        chk($sformatf("v%0d cmd_count", vi), n, v.n_cmds);
        chk($sformatf("v%0d done_pulse", vi), done, 1);
        chk($sformatf("v%0d done_valid", vi), valid, 0);
        tick();
        chk($sformatf("v%0d done_clear", vi), done, 0);
        chk($sformatf("v%0d idle_busy", vi), busy, 0);
    endtask

    task automatic check_all_zero(input string t);
        chk({t, " valid"},  valid,  0);
        chk({t, " step"},   step,   0);
        chk({t, " head"},   head,   0);
        chk({t, " a"},      tile_a, 0);
        chk({t, " b"},      tile_b, 0);
        chk({t, " k"},      tile_k, 0);
        chk({t, " last_k"}, last_k, 0);
        chk({t, " busy"},   busy,   0);
        chk({t, " done"},   done,   0);
        chk({t, " error"},  error,  0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        layer = '0; n_heads = '0;
        tile_s = '0; tile_e = '0; tile_p = '0; tile_f = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        tbl[0]  = '{Attention,       1, 2, 1, 1, 1,  16, 1'b0, 1'b0};
        tbl[1]  = '{Feedforward,     1, 1, 2, 1, 3,  12, 1'b0, 1'b0};
        tbl[2]  = '{SingleAttention, 3, 1, 1, 1, 1,  15, 1'b0, 1'b0};
        tbl[3]  = '{SingleAttention, 5, 1, 1, 1, 1,   0, 1'b1, 1'b0};
        tbl[4]  = '{SingleAttention, 3, 1, 1, 0, 1,   0, 1'b1, 1'b0};
        tbl[5]  = '{Linear,          1, 1, 3, 1, 1,   3, 1'b0, 1'b1};
        tbl[6]  = '{Attention,       0, 1, 1, 1, 1,   0, 1'b1, 1'b0};
        tbl[7]  = '{Linear,          1, 1, 1, 1, 0,   0, 1'b1, 1'b0};
        tbl[8]  = '{Attention,       4, 1, 1, 1, 1,  24, 1'b0, 1'b1};
        tbl[9]  = '{Feedforward,     0, 1, 1, 0, 1,   2, 1'b0, 1'b0};
        tbl[10] = '{Attention,       2, 2, 3, 2, 1, 128, 1'b0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            run_vec(tbl[i], i);
            tick();
        end

        // Abort coincident with a handshake in the middle of QK.
        ready = 1'b0;
        start_cfg(Attention, 1, 2, 1, 1, 1);
        ready = 1'b1;
        cyc = 0;
        while (!(step == 4'(QK) && tile_b == 16'd1) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("abort_reach_qk", (step == 4'(QK) && tile_b == 16'd1), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ready = 1'b0;
        chk("abort valid", valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort step", step, 0);
        tick();
        chk("abort done_later", done, 0);
        start_cfg(Attention, 1, 2, 1, 1, 1);
        chk("restart step", step, 4'(Q));
        chk("restart a", tile_a, 0);
        chk("restart b", tile_b, 0);
        chk("restart k", tile_k, 0);
        chk("restart valid", valid, 1);
        tick();
        chk("stall_hold step", step, 4'(Q));
        chk("stall_hold valid", valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort2 busy", busy, 0);

        // Start while busy is ignored; reset mid-run clears everything.
        start_cfg(Linear, 1, 1, 3, 1, 1);
        chk("busy_start step", step, 4'(MatMul));
        start_cfg(Feedforward, 1, 1, 5, 1, 2);
        chk("ignored_start step", step, 4'(MatMul));
        chk("ignored_start k", tile_k, 0);
        chk("ignored_start err", error, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("pre_reset k", tile_k, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_reset");
        tick();
        check_all_zero("after_reset");

        // Maximum tile count is a legal bound.
        start_cfg(Linear, 1, 1, 65535, 1, 1);
        chk("max_bound err", error, 0);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("max_bound k%0d", i), tile_k, i);
            chk($sformatf("max_bound last_k%0d", i), last_k, 0);
            tick();
        end
        ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("max_bound abort", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
